rr_arb32_idx: RTL and testbench

Round-robin arbiter over 32 request lines. It produces a registered 5-bit grant index plus an enable, and sits directly upstream of the 5-to-32 one-hot decoder: `Idx` drives the decoder's `Din[4:0]` and `En` drives its `En`, so the decoder output is the one-hot grant vector. A grant is held until the owner signals `Done`, or until a watchdog timeout forces release.

---
 rtl/rr_arb32_idx_if.sv | 10 +
 rtl/rr_arb32_idx.sv | 50 +++++
 tb/tb_rr_arb32_idx.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rr_arb32_idx_if.sv
// rr_arb32_idx_if: request/grant bundle between 32 requesters and the round-robin arbiter
interface rr_arb32_idx_if;
  logic [31:0] req;
  logic        done;
  logic [4:0]  idx;
  logic        en;
  logic        timeout;
  modport master (output req, output done, input idx, input en, input timeout);
  modport slave  (input req, input done, output idx, output en, output timeout);
endinterface

// File: rtl/rr_arb32_idx.sv
// rr_arb32_idx: round-robin arbiter over 32 requesters with registered grant index and hold watchdog
module rr_arb32_idx #(
  parameter int TIMEOUT = 16
) (
  input logic           clk,
  input logic           rst,
  rr_arb32_idx_if.slave bus
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  logic [0:0]    state;
  logic [4:0]    ptr;
  logic [4:0]    pos;
  logic [CW-1:0] cnt;
  // distance from ptr to the first requester at or after it, wrapping mod 32
  always_comb begin
    pos = '0;
    for (int i = 31; i >= 0; i--)
      if (bus.req[ptr + 5'(i)]) pos = 5'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      bus.idx     <= '0;
      bus.en      <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      if (state == IDLE) begin
        if (|bus.req) begin
          state   <= GRANT;
          bus.idx <= ptr + pos;
          bus.en  <= 1'b1;
          cnt     <= '0;
        end
      end else if (bus.done || cnt == CMAX) begin
        state       <= IDLE;
        bus.en      <= 1'b0;
        ptr         <= bus.idx + 5'd1;
        bus.timeout <= !bus.done;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rr_arb32_idx.sv
// tb_rr_arb32_idx: directed and randomized checks of rr_arb32_idx against a cycle-level reference model
module tb_rr_arb32_idx;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  rr_arb32_idx_if bus ();
  rr_arb32_idx #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic        m_en;
  logic [4:0]  m_idx;
  logic        m_to;
  int          m_ptr;
  int          m_held;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic int first_from(input logic [31:0] r, input int p);
    for (int k = 0; k < 32; k++)
      if (r[(p + k) % 32]) return (p + k) % 32;
    return -1;
  endfunction
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_en = 0; m_idx = 0; m_to = 0; m_ptr = 0; m_held = 0;
    end else begin
      m_to = 0;
      if (!m_en) begin
        if (bus.req != 0) begin
          m_idx = 5'(first_from(bus.req, m_ptr));
          m_en = 1;
          m_held = 1;
        end
      end else if (bus.done) begin
        m_en = 0;
        m_ptr = (m_idx + 1) % 32;
      end else if (m_held == TO) begin
        m_en = 0;
        m_ptr = (m_idx + 1) % 32;
        m_to = 1;
      end else begin
        m_held++;
      end
    end
    #1;
    chk("en", 32'(bus.en), 32'(m_en));
    chk("idx", 32'(bus.idx), 32'(m_idx));
    chk("timeout", 32'(bus.timeout), 32'(m_to));
  endtask
  task automatic go_idle();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
  endtask
  initial begin
    int hi;
    m_en = 0; m_idx = 0; m_to = 0; m_ptr = 0; m_held = 0;
    bus.req = '1;
    bus.done = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    chk("rst_en", 32'(bus.en), 32'd0);
    rst = 1'b0;
    step();
    chk("first_grant_idx", 32'(bus.idx), 32'd0);
    chk("first_grant_en", 32'(bus.en), 32'd1);
    go_idle();
    bus.req = 32'h0000_0010;
    step();
    chk("single_idx", 32'(bus.idx), 32'd4);
    repeat (5) step();
    chk("single_hold", 32'(bus.idx), 32'd4);
    go_idle();
    chk("single_release", 32'(bus.en), 32'd0);
    bus.req = 32'h0000_0021;
    step();
    chk("ptr_after_4", 32'(bus.idx), 32'd5);
    go_idle();
    bus.req = 32'h8000_0001;
    for (int i = 0; i < 10; i++) begin
      bus.done = m_en;
      step();
    end
    bus.done = 1'b0;
    if (m_en) go_idle();
    bus.req = 32'h0000_0100;
    step();
    hi = 0;
    while (bus.en && hi < 40) begin
      hi++;
      step();
    end
    chk("wd_hold_cycles", 32'(hi), 32'(TO));
    chk("wd_pulse", 32'(bus.timeout), 32'd1);
    step();
    chk("wd_regrant_en", 32'(bus.en), 32'd1);
    chk("wd_regrant_idx", 32'(bus.idx), 32'd8);
    repeat (TO - 1) step();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk("collide_en", 32'(bus.en), 32'd0);
    chk("collide_timeout", 32'(bus.timeout), 32'd0);
    bus.req = 32'h0010_0000;
    step();
    chk("mid_grant_idx", 32'(bus.idx), 32'd20);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_en", 32'(bus.en), 32'd0);
    chk("mid_rst_idx", 32'(bus.idx), 32'd0);
    bus.req = 32'h0010_0002;
    step();
    chk("post_rst_idx", 32'(bus.idx), 32'd1);
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(3))
        0: bus.req = '0;
        1: bus.req = 32'(1) << $urandom_range(31);
        2: bus.req = $urandom & $urandom;
        default: bus.req = $urandom;
      endcase
      bus.done = ($urandom_range(5) == 0);
      rst = ($urandom_range(99) == 0);
      step();
    end
    rst = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
